servo_pulse_monitor: RTL
========================

SERVO_PULSE_MONITOR -- requirements
Module: servo_pulse_monitor

Interface
REQ-001 Parameter TIMEOUT, default 24'd2500000, is the loss-of-signal limit in clk cycles (25 ms at 100 MHz).
REQ-002 Parameter TOL, default 24'd5000, is the classification tolerance in clk cycles (+/-50 us).
REQ-003 Port clk, input, 1 bit: 100 MHz clock; all logic on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port control, input, 1 bit: servo PWM from the pulse generator, same clock domain.
REQ-006 Port width, output, 24 bits: high time of the last complete frame, in cycles.
REQ-007 Port period, output, 24 bits: rise-to-rise distance of the last complete frame, in cycles.
REQ-008 Port pos, output, 2 bits: decoded position, 00 left, 01 right, 10 middle, 11 unclassified.
REQ-009 Port pos_ok, output, 1 bit: width fell inside a classification window.
REQ-010 Port period_ok, output, 1 bit: period within 2000001 +/- 10000 cycles.
REQ-011 Port valid, output, 1 bit: one-cycle strobe, new width/period/pos published.
REQ-012 Port lost, output, 1 bit: sticky loss-of-signal flag.

Function
REQ-013 control SHALL be registered twice (c1, c2); rise = c1 & ~c2 and fall = ~c1 & c2; no other logic samples control.
REQ-014 FSM states SHALL be IDLE, HIGH, LOW.
REQ-015 IDLE: on rise -> HIGH and clear the cycle counter; a high level present at reset exit SHALL be ignored until a fall then a rise occurs.
REQ-016 HIGH: on fall -> LOW and latch the counter as the internal high time.
REQ-017 LOW: on rise -> HIGH, publish results, and restart the counter.
REQ-018 The counter SHALL count cycles since the last rise, saturate at 24'hFFFFFF, and never wrap.
REQ-019 width SHALL equal the number of clk edges on which control was sampled high.
REQ-020 period SHALL equal the cycle distance between consecutive rises.
REQ-021 Publication SHALL update width, period, pos, pos_ok and period_ok in one cycle, with valid high for exactly that cycle.
REQ-022 valid SHALL assert 2 cycles after the clock edge at which control is first sampled high for the following frame.
REQ-023 The first valid after reset or after loss SHALL require one complete frame (rise, fall, rise); no partial frame is ever published.
REQ-024 Classification SHALL be by width, with inclusive bounds:
- left (00) if |width-100001| <= TOL;
- middle (10) if |width-150001| <= TOL;
- right (01) if |width-200001| <= TOL;
- otherwise pos=11 and pos_ok=0.
REQ-025 Outputs SHALL hold their values between valid strobes.
REQ-026 If the counter reaches TIMEOUT in HIGH or LOW (stuck high or no rise), lost SHALL set the next cycle, the FSM SHALL go to IDLE, and valid SHALL NOT pulse.
REQ-027 lost SHALL clear only on the next valid strobe or on reset.
REQ-028 A rise and a timeout in the same cycle SHALL be resolved in favour of the rise.
REQ-029 A glitch (one-cycle high or low) SHALL be measured literally: no filtering, and the result is classified 11 by width.

Reset
REQ-030 While rst is high at a clk edge, the FSM SHALL enter IDLE and the counter and c1/c2 SHALL clear.
REQ-031 During reset, width, period, pos, pos_ok, period_ok, valid and lost SHALL all be 0.
REQ-032 Reset asserted mid-frame SHALL discard the partial measurement, with no valid on exit.

Verification
REQ-033 Drive 3 frames of high 100001 / period 2000001 -> 2 valid strobes; each shows width=100001, period=2000001, pos=00, pos_ok=1, period_ok=1.
REQ-034 Switch from 150001 to 200001 high mid-run -> first post-change strobe shows pos=01; preceding strobe shows pos=10.
REQ-035 High time of 120000 cycles -> pos=11, pos_ok=0, width=120000.
REQ-036 Hold control low 3,000,000 cycles after a good frame -> lost=1 at count 2500000 plus 1 cycle and no valid; resume frames -> lost clears on the 2nd rise.
REQ-037 Bench requirements for reset:
- rst pulsed in mid-HIGH -> all outputs 0 and no valid until a full new frame;
- control high at reset release -> no valid until fall, rise, fall, rise.
REQ-038 Period 1,980,000 with high 150001 -> pos=10, pos_ok=1, period_ok=0.

Source files
------------

// File: rtl/servo_pulse_monitor.sv
// rtl/servo_pulse_monitor.sv - servo PWM frame measurement, position decode and loss-of-signal detection
// Measures high time and rise-to-rise period per frame, classifies position, flags loss of signal.
module servo_pulse_monitor #(
  parameter logic [23:0] TIMEOUT    = 24'd2500000,
  parameter logic [23:0] TOL        = 24'd5000,
  parameter logic [23:0] LEFT_W     = 24'd100001,
  parameter logic [23:0] MID_W      = 24'd150001,
  parameter logic [23:0] RIGHT_W    = 24'd200001,
  parameter logic [23:0] PERIOD_NOM = 24'd2000001,
  parameter logic [23:0] PERIOD_TOL = 24'd10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        control,
  output logic [23:0] width,
  output logic [23:0] period,
  output logic [1:0]  pos,
  output logic        pos_ok,
  output logic        period_ok,
  output logic        valid,
  output logic        lost
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t      state_q, state_d;
  logic        c1_q, c2_q;
  logic        smp_q, armed_q, armed_d;
  logic [23:0] cnt_q, cnt_d, cnt_inc;
  logic [23:0] hi_q, hi_d;
  logic [23:0] raw_w_q, raw_w_d, raw_p_q, raw_p_d;
  logic        pend_q, pend_d;
  logic        lost_set;
  logic [23:0] width_q, period_q;
  logic [1:0]  pos_q, pos_c;
  logic        pos_ok_q, pos_ok_c, period_ok_q, period_ok_c;
  logic        valid_q, lost_q;
  logic        rise, fall, timeout;

  function automatic logic [23:0] absdiff(input logic [23:0] a, input logic [23:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  assign rise    = c1_q & ~c2_q;
  assign fall    = ~c1_q & c2_q;
  assign cnt_inc = (cnt_q == 24'hFFFFFF) ? cnt_q : cnt_q + 24'd1;
  assign timeout = (cnt_q >= TIMEOUT);

  // A level already high at reset exit must not look like a rise: arm only once low is seen.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    raw_w_d  = raw_w_q;
    raw_p_d  = raw_p_q;
    pend_d   = 1'b0;
    lost_set = 1'b0;
    armed_d  = armed_q | (smp_q & ~c1_q);
    case (state_q)
      IDLE: begin
        cnt_d = 24'd0;
        if (rise && armed_q) state_d = HIGH;
      end
      HIGH: begin
        cnt_d = cnt_inc;
        if (timeout) begin
          state_d  = IDLE;
          lost_set = 1'b1;
        end else if (fall) begin
          state_d = LOW;
          hi_d    = cnt_inc;
        end
      end
      LOW: begin
        cnt_d = cnt_inc;
        if (rise) begin
          state_d = HIGH;
          cnt_d   = 24'd0;
          raw_w_d = hi_q;
          raw_p_d = cnt_inc;
          pend_d  = 1'b1;
        end else if (timeout) begin
          state_d  = IDLE;
          lost_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pos_c    = 2'b11;
    pos_ok_c = 1'b0;
    if (absdiff(raw_w_q, LEFT_W) <= TOL) begin
      pos_c    = 2'b00;
      pos_ok_c = 1'b1;
    end else if (absdiff(raw_w_q, MID_W) <= TOL) begin
      pos_c    = 2'b10;
      pos_ok_c = 1'b1;
    end else if (absdiff(raw_w_q, RIGHT_W) <= TOL) begin
      pos_c    = 2'b01;
      pos_ok_c = 1'b1;
    end
    period_ok_c = (absdiff(raw_p_q, PERIOD_NOM) <= PERIOD_TOL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      c1_q        <= 1'b0;
      c2_q        <= 1'b0;
      smp_q       <= 1'b0;
      armed_q     <= 1'b0;
      cnt_q       <= 24'd0;
      hi_q        <= 24'd0;
      raw_w_q     <= 24'd0;
      raw_p_q     <= 24'd0;
      pend_q      <= 1'b0;
      width_q     <= 24'd0;
      period_q    <= 24'd0;
      pos_q       <= 2'b00;
      pos_ok_q    <= 1'b0;
      period_ok_q <= 1'b0;
      valid_q     <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      c1_q    <= control;
      c2_q    <= c1_q;
      smp_q   <= 1'b1;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      raw_w_q <= raw_w_d;
      raw_p_q <= raw_p_d;
      pend_q  <= pend_d;
      valid_q <= pend_q;
      // Second pipeline stage: classify the latched frame and publish everything together.
      if (pend_q) begin
        width_q     <= raw_w_q;
        period_q    <= raw_p_q;
        pos_q       <= pos_c;
        pos_ok_q    <= pos_ok_c;
        period_ok_q <= period_ok_c;
        lost_q      <= 1'b0;
      end else if (lost_set) begin
        lost_q <= 1'b1;
      end
    end
  end

  assign width     = width_q;
  assign period    = period_q;
  assign pos       = pos_q;
  assign pos_ok    = pos_ok_q;
  assign period_ok = period_ok_q;
  assign valid     = valid_q;
  assign lost      = lost_q;

endmodule
